nibble_rx: RTL

- Serial-to-parallel receive stage feeding the div3 combinational divider.
- Deserializes a UART-style frame carrying one 4-bit operand: start bit, W data bits MSB-first, stop bit.
- Presents the operand on a held register whose output drives the divider input `i` directly.
- Flags each new operand with a one-cycle valid pulse and reports framing errors.

---
 rtl/nibble_rx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/nibble_rx.sv
// nibble_rx: UART-style receive stage for one W-bit operand.
// Frame = start bit (0), W data bits MSB-first, stop bit (1), each OVS clocks long.
// The held o_data register feeds the div3 divider input directly.
module nibble_rx #(
  parameter int OVS = 4,
  parameter int W   = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_frame_err,
  output logic          o_busy,
  output logic [CW-1:0] o_cnt
);

  localparam int CYW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int IDXW = $clog2(W + 1);

  localparam logic [CYW-1:0]  CYC_LAST = CYW'(OVS - 1);
  localparam logic [CYW-1:0]  CYC_MID  = CYW'(OVS / 2 - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // synchronizer
  logic            sync1_r;
  logic            rs_r;

  // fsm state and datapath registers
  state_t          state_r;
  state_t          state_s;
  logic [CYW-1:0]  cyc_r;
  logic [CYW-1:0]  cyc_s;
  logic [IDXW-1:0] idx_r;
  logic [IDXW-1:0] idx_s;
  logic [W-1:0]    shift_r;
  logic [W-1:0]    shift_s;

  // output registers and their next values
  logic [W-1:0]    data_r;
  logic [W-1:0]    data_s;
  logic            valid_r;
  logic            valid_s;
  logic            ferr_r;
  logic            ferr_s;
  logic            busy_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rs_r    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rs_r    <= sync1_r;
    end
  end

  // Next-state and next-output decode; all decisions use the synchronized line.
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    data_s  = data_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    cnt_s   = cnt_r;

    case (state_r)
      IDLE: begin
        if (rs_r == 1'b0) begin
          state_s = START;
          cyc_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        // Re-check the line in the middle of the start bit to reject glitches.
        if (cyc_r == CYC_MID) begin
          cyc_s = '0;
          if (rs_r == 1'b0) begin
            state_s = DATA;
            idx_s   = '0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cyc_s = cyc_r + CYW'(1);
        end
      end

      DATA: begin
        // Start bit was sampled mid-bit, so a full-bit stride stays mid-bit.
        if (cyc_r == CYC_LAST) begin
          cyc_s   = '0;
          shift_s = {shift_r[W-2:0], rs_r};
          idx_s   = idx_r + IDXW'(1);
          if (idx_r == IDX_LAST) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          cyc_s = cyc_r + CYW'(1);
        end
      end

      STOP: begin
        if (cyc_r == CYC_LAST) begin
          cyc_s = '0;
          if (rs_r == 1'b1) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            cnt_s   = cnt_r + CW'(1);
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = BREAK;
          end
        end else begin
          cyc_s = cyc_r + CYW'(1);
        end
      end

      BREAK: begin
        // A line held low must return high before another start bit counts.
        if (rs_r == 1'b1) begin
          state_s = IDLE;
          cyc_s   = '0;
        end else begin
          state_s = BREAK;
        end
      end

      default: begin
        state_s = IDLE;
        cyc_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cyc_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
    end
  end

  // Registered outputs; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      data_r  <= data_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
      busy_r  <= (state_s != IDLE);
      cnt_r   <= cnt_s;
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = ferr_r;
  assign o_busy      = busy_r;
  assign o_cnt       = cnt_r;

endmodule
